// File: rtl/dispatch_1to8_if.sv
// dispatch_1to8_if
// ----------------
// Bundles the producer-side and consumer-side handshakes of the eight-way
// word dispatcher.
//   Producer side : in_valid, in_ready, in_data[31:0], in_sel[2:0], in_bcast
//   Consumer side : out_valid[7:0], out_ready[7:0], out_data0..out_data7[31:0]
//   Status        : accept_count[31:0]
// Modports:
//   slave  - the dispatcher itself
//   master - the environment (producer plus the eight consumers)
interface dispatch_1to8_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
  logic [31:0] out_data4;
  logic [31:0] out_data5;
  logic [31:0] out_data6;
  logic [31:0] out_data7;
  logic [31:0] accept_count;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid,
    output out_data0, out_data1, out_data2, out_data3,
    output out_data4, out_data5, out_data6, out_data7,
    output accept_count
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid,
    input  out_data0, out_data1, out_data2, out_data3,
    input  out_data4, out_data5, out_data6, out_data7,
    input  accept_count
  );
endinterface

// File: rtl/dispatch_1to8.sv
// dispatch_1to8
// -------------
// Eight-way dispatcher for 32-bit words. One word per cycle is accepted over
// a valid/ready handshake and written either to the channel named by in_sel
// or, with in_bcast, to all eight channels. Each channel is a single-entry
// buffer that drains through its own valid/ready handshake; a channel can be
// drained and refilled on the same edge.
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous, active-high; clears buffers, full bits and count
//   bus   - dispatch_1to8_if.slave (producer handshake, eight consumer
//           handshakes, out_data0..7, accept_count)
module dispatch_1to8 (
  input  logic           clock,
  input  logic           reset,
  dispatch_1to8_if.slave bus
);

  logic [7:0]  full_q;
  logic [31:0] buf_q [8];
  logic [31:0] count_q;

  logic [7:0]  can_take;
  logic [7:0]  drain;
  logic [7:0]  fill;
  logic        accept;

  // A channel can take a word if it is empty or being drained this cycle.
  assign can_take = ~full_q | bus.out_ready;

  // Broadcast waits for every channel so a word is never half-delivered.
  // in_ready is deliberately independent of in_valid.
  assign bus.in_ready = bus.in_bcast ? (&can_take) : can_take[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = full_q & bus.out_ready;

  always_comb begin
    // NOTE: default first so every path assigns fill and no latch is inferred.
    fill = 8'h00;
    if (accept) begin
      fill = bus.in_bcast ? 8'hFF : (8'b0000_0001 << bus.in_sel);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q  <= 8'h00;
      count_q <= 32'h0;
      // NOTE: the buffers are reset too because out_data must read zero
      // while reset is asserted; this keeps them out of RAM macros.
      for (int k = 0; k < 8; k++) begin
        buf_q[k] <= 32'h0;
      end
    end else begin
      // A fill on the same edge as a drain wins, keeping the channel full.
      full_q  <= (full_q & ~drain) | fill;
      count_q <= count_q + {31'b0, accept};
      for (int k = 0; k < 8; k++) begin
        if (fill[k]) begin
          buf_q[k] <= bus.in_data;
        end
      end
    end
  end

  assign bus.out_valid    = full_q;
  assign bus.accept_count = count_q;
  assign bus.out_data0    = buf_q[0];
  assign bus.out_data1    = buf_q[1];
  assign bus.out_data2    = buf_q[2];
  assign bus.out_data3    = buf_q[3];
  assign bus.out_data4    = buf_q[4];
  assign bus.out_data5    = buf_q[5];
  assign bus.out_data6    = buf_q[6];
  assign bus.out_data7    = buf_q[7];

endmodule

// File: tb/tb_dispatch_1to8.sv
// tb_dispatch_1to8
// ----------------
// Scoreboard bench for dispatch_1to8. The stimulus process pushes the word it
// expects each channel to deliver into that channel's queue; a separate
// monitor pops and compares on every consumer transfer (out_valid & out_ready
// sampled on the falling edge). Inputs change 1 time unit after the rising
// edge; direct checks on registered state are made at the same point.
module tb_dispatch_1to8;

  logic clock;
  logic reset;

  dispatch_1to8_if bus ();

  dispatch_1to8 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q [8][$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] out_word(input int k);
    case (k)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      3: return bus.out_data3;
      4: return bus.out_data4;
      5: return bus.out_data5;
      6: return bus.out_data6;
      default: return bus.out_data7;
    endcase
  endfunction

  // Monitor: every consumer transfer must match the head of its queue.
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_unexpected ch%0d: got %08h, expected no word", k, out_word(k));
          end else begin
            check($sformatf("drain_ch%0d", k), out_word(k), exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 8; k++) exp_q[k].delete();
  endtask

  // Present one word for the current cycle and check in_ready against the
  // hand-derived value. An expected accept records the delivery expectation.
  task automatic present(input logic [2:0] sel, input logic bcast,
                         input logic [31:0] data, input logic exp_ready,
                         input string name);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_bcast = bcast;
    bus.in_data  = data;
    #1;
    check(name, {31'b0, bus.in_ready}, {31'b0, exp_ready});
    if (exp_ready) begin
      if (bcast) begin
        for (int k = 0; k < 8; k++) exp_q[k].push_back(data);
      end else begin
        exp_q[sel].push_back(data);
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bcast  = 1'b1;
    bus.in_sel    = 3'd0;
    bus.in_data   = 32'h1111_1111;
    bus.out_ready = 8'h00;

    // Reset state, with a broadcast presented that must not be accepted.
    #2;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {24'b0, bus.out_valid}, 32'h0);
    check("rst_count", bus.accept_count, 32'h0);
    check("rst_data3", bus.out_data3, 32'h0);
    tick();
    tick();
    idle();
    reset = 1'b0;
    tick();
    check("post_rst_count", bus.accept_count, 32'h0);
    check("post_rst_valid", {24'b0, bus.out_valid}, 32'h0);

    // Single addressed word to channel 3, consumer stalled.
    present(3'd3, 1'b0, 32'hDEAD_BEEF, 1'b1, "t1_in_ready");
    tick();
    idle();
    bus.in_sel = 3'd3;
    #1;
    check("t1_out_valid", {24'b0, bus.out_valid}, 32'h08);
    check("t1_data3", bus.out_data3, 32'hDEAD_BEEF);
    check("t1_count", bus.accept_count, 32'd1);
    check("t1_in_ready_full", {31'b0, bus.in_ready}, 32'd0);

    // Channel 5: fill, then drain and refill on the same edge.
    present(3'd5, 1'b0, 32'hAAAA_0005, 1'b1, "t2_fill_ready");
    tick();
    bus.out_ready = 8'h20;
    present(3'd5, 1'b0, 32'h1234_5678, 1'b1, "t2_refill_ready");
    tick();
    idle();
    bus.out_ready = 8'h00;
    check("t2_out_valid", {24'b0, bus.out_valid}, 32'h28);
    check("t2_data5", bus.out_data5, 32'h1234_5678);
    check("t2_count", bus.accept_count, 32'd3);

    // Drain channels 3 and 5 so only channel 2 will block the broadcast.
    bus.out_ready = 8'h28;
    tick();
    bus.out_ready = 8'h00;
    check("t3_drained", {24'b0, bus.out_valid}, 32'h00);
    present(3'd2, 1'b0, 32'h2222_2222, 1'b1, "t3_fill2_ready");
    tick();
    present(3'd0, 1'b1, 32'hCAFE_F00D, 1'b0, "t3_bcast_blocked");
    tick();
    check("t3_blocked_valid", {24'b0, bus.out_valid}, 32'h04);
    check("t3_blocked_count", bus.accept_count, 32'd4);
    bus.out_ready = 8'h04;
    present(3'd0, 1'b1, 32'hCAFE_F00D, 1'b1, "t3_bcast_ready");
    tick();
    idle();
    bus.out_ready = 8'h00;
    check("t3_out_valid", {24'b0, bus.out_valid}, 32'hFF);
    check("t3_data0", bus.out_data0, 32'hCAFE_F00D);
    check("t3_data7", bus.out_data7, 32'hCAFE_F00D);
    check("t3_count", bus.accept_count, 32'd5);
    bus.out_ready = 8'hFF;
    tick();
    bus.out_ready = 8'h00;
    check("t3_all_drained", {24'b0, bus.out_valid}, 32'h00);

    // Streaming 0..15 round-robin from a fresh reset.
    reset = 1'b1;
    flush();
    tick();
    reset = 1'b0;
    bus.out_ready = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      present(3'(i % 8), 1'b0, 32'(i), 1'b1, $sformatf("t4_ready_%0d", i));
      tick();
    end
    idle();
    check("t4_count", bus.accept_count, 32'd16);
    check("t4_last_valid", {24'b0, bus.out_valid}, 32'h80);
    tick();
    check("t4_valid_clear", {24'b0, bus.out_valid}, 32'h00);

    // Asynchronous reset between edges, in the middle of a stream.
    present(3'd1, 1'b0, 32'h0000_0A01, 1'b1, "t5_ready_a");
    tick();
    present(3'd2, 1'b0, 32'h0000_0A02, 1'b1, "t5_ready_b");
    tick();
    bus.out_ready = 8'h00;
    present(3'd4, 1'b0, 32'h0000_0A04, 1'b1, "t5_ready_c");
    tick();
    present(3'd6, 1'b0, 32'h0000_0A06, 1'b1, "t5_ready_d");
    #1;
    reset = 1'b1;
    #1;
    flush();
    check("t5_async_valid", {24'b0, bus.out_valid}, 32'h00);
    check("t5_async_count", bus.accept_count, 32'h0);
    tick();
    idle();
    reset = 1'b0;
    present(3'd1, 1'b0, 32'h0000_0B01, 1'b1, "t5_first_ready");
    tick();
    idle();
    check("t5_first_count", bus.accept_count, 32'd1);
    bus.out_ready = 8'h02;
    tick();
    bus.out_ready = 8'h00;

    // Counter wrap from a preloaded all-ones value.
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    check("t6_preload", bus.accept_count, 32'hFFFF_FFFF);
    present(3'd0, 1'b0, 32'h0F0F_0F0F, 1'b1, "t6_ready");
    tick();
    idle();
    check("t6_wrap", bus.accept_count, 32'h0);
    bus.out_ready = 8'h01;
    tick();
    bus.out_ready = 8'h00;
    tick();

    // Every expected delivery must have been observed.
    for (int k = 0; k < 8; k++) begin
      check($sformatf("queue_empty_ch%0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_1to8.md
# dispatch_1to8

Eight-way dispatcher for 32-bit words, the write-side counterpart of the eight-input word selector used on the datapath read side. It accepts one word per cycle over a valid/ready handshake and steers it, by a 3-bit select or by broadcast, into one of eight single-entry output buffers. Each buffer drains independently through its own valid/ready handshake. It sits between a single producer, such as the FPU result bus, and eight consumers, such as register-file write ports or functional-unit operand queues.

## Interface
- No parameters; data width is fixed at 32, channel count fixed at 8.
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  dispatcher can accept the presented word this cycle
- in_data  input  32  word to dispatch
- in_sel  input  3  destination channel 0..7; ignored when in_bcast=1
- in_bcast  input  1  write the word to all eight channels
- out_valid  output  8  bit k: channel k buffer holds a word
- out_ready  input  8  bit k: consumer k takes the word this cycle
- out_data0 … out_data7  output  32 each  channel buffer contents
- accept_count  output  32  number of input words accepted since reset

## Operation
- Per-channel state: full[k] (drives out_valid[k]) and buf[k] (drives out_data k).
- Channel k can take a word when can_take[k] = ~full[k] | out_ready[k]. Same-cycle drain plus fill is allowed.
- in_ready = in_bcast ? &can_take : can_take[in_sel]. This is combinational from in_sel, in_bcast, the full[] state and out_ready. It never depends on in_valid.
- Input accept when in_valid & in_ready:
  - Addressed mode: buf[in_sel] <= in_data and full[in_sel] <= 1.
  - Broadcast mode: all eight buffers load in_data and all full bits set.
  - accept_count increments by 1 per accept. A broadcast counts once.
- Drain of channel k when out_valid[k] & out_ready[k]: full[k] <= 0, unless the same edge also fills k, in which case full[k] stays 1 and buf[k] takes the new word.
- out_ready[k] while out_valid[k]=0 has no effect.
- buf[k] holds its value while full[k]=1 and no fill occurs. After a drain, buf[k] keeps its old value; consumers must qualify it with out_valid.
- in_sel, in_bcast and in_data are sampled only on an accepting edge.
- accept_count is 32-bit unsigned and wraps from 0xFFFFFFFF to 0x00000000 with no flag.

## Timing
- Reset values (asynchronous, effective while reset=1): out_valid = 8'h00, all out_data = 32'h0, accept_count = 0.
- During reset, in_ready follows the combinational rule with full = 0, so it reads 1. Words presented during reset are not accepted.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N. The earliest drain is at edge N+1.
- Throughput:
  - One word per cycle into any channel whose consumer holds out_ready high.
  - Back-to-back words to the same channel with its out_ready low: the first is accepted and in_ready drops on the next cycle.
- Broadcast waits until every channel can take. Partial broadcast never occurs.
- Reset asserted mid-transfer discards all buffered words and the count. The first accept after release is counted as 1.

## Test plan
- Reset, then in_sel=3, in_data=32'hDEADBEEF, in_valid=1 for one cycle, out_ready=0 -> out_valid=8'h08, out_data3=DEADBEEF, accept_count=1, in_ready=0 while in_sel=3.
- Channel 5 full, out_ready[5]=1, new word 32'h12345678 to channel 5 same cycle -> out_valid[5] stays 1, out_data5=12345678 next cycle, count +1.
- Broadcast 32'hCAFEF00D with channel 2 full and out_ready[2]=0 -> in_ready=0, nothing written. Raise out_ready[2] -> accept, out_valid=8'hFF, all out_data=CAFEF00D, count +1.
- Streaming 0..15 round-robin across in_sel 0..7 with out_ready=8'hFF -> in_ready constantly 1, each word visible exactly one cycle on its channel, count=16.
- Reset pulse asserted asynchronously mid-stream (between edges) -> out_valid=0 and count=0 immediately, before the next clock edge.
- Force accept_count to 0xFFFFFFFF through 2^32 accepts (or a bench preload), accept one more word -> accept_count=0.
